memory_unit: RTL and testbench
==============================

// Module: memory_unit
// PURPOSE
//   16-bit word-addressed data memory with memory-mapped I/O for the processor datapath.
//   Holds separate kernel and user RAM banks, an output register and an input port.
//   Flags illegal accesses (AccInv) so the control unit can trap.
// PARAMETERS
//   AW      10   RAM index width; each bank holds 2**AW 16-bit words
//   IN_ADDR 16'hFFFE  input-port address (read-only)
//   OUT_ADDR 16'hFFFF output-register address (read/write)
// PORTS
//   Clk        in   1   system clock, all state updates on rising edge
//   Rst        in   1   synchronous active-high reset
//   Addr       in   16  word address
//   WriteData  in   16  data to store
//   WriteFlag  in   1   1 = write this cycle, 0 = read
//   KernelFlag in   1   1 = kernel mode (may access kernel bank)
//   Input      in   16  external input value
//   InputRst   in   1   synchronous clear of InputRecv
//   Output     out  16  output register (memory-mapped at OUT_ADDR)
//   ReadData   out  16  read data
//   AccInv     out  1   illegal access this cycle
//   InputRecv  out  1   sticky "input value consumed" flag
// BEHAVIOUR
//   Address map:
//     0x0000-0x3FFF  kernel bank; valid only if Addr[13:AW]==0 and KernelFlag=1
//     0x4000-0x7FFF  user bank; valid only if Addr[13:AW]==0 (any mode)
//     IN_ADDR        read-only: ReadData = Input
//     OUT_ADDR       read: ReadData = Output; write: Output <= WriteData
//     all else       invalid
//   Bank index = Addr[AW-1:0].
//   AccInv is combinational and asserts when the current access is invalid:
//     - unmapped address;
//     - kernel bank with KernelFlag=0;
//     - write to IN_ADDR;
//     - bank address with Addr[13:AW]!=0.
//   Reads are combinational, zero latency: ReadData follows Addr in the same cycle.
//   ReadData = 0 whenever AccInv=1.
//   Writes commit on the rising Clk edge when WriteFlag=1 and AccInv=0.
//     Readback of the new value is available from the next cycle.
//     An invalid write changes no state.
//   InputRecv: set on an edge where Addr==IN_ADDR and WriteFlag=0. It stays set until cleared.
//     Cleared on an edge with InputRst=1 or Rst=1; the clear wins over a simultaneous set.
//   Rst clears Output to 0 and InputRecv to 0.
//     RAM contents are not cleared; RAM is undefined until written.
//     Rst also blocks any write on the same edge.
//   KernelFlag is sampled per access. A mode change takes effect immediately on AccInv.
// STRUCTURE
//   Shared package: address-map constants (KERNEL_BASE 0x0000, USER_BASE 0x4000,
//     IN_ADDR, OUT_ADDR) and region decode enum {REG_KERNEL, REG_USER, REG_IN, REG_OUT, REG_BAD}.
//   One sub-module, mem_bank: 2**AW x 16 RAM with async read and sync write, instantiated
//     twice (kernel, user).
//   Top level holds the address decoder, AccInv logic, Output register and InputRecv flag.
// TESTING
//   1. Rst=1 for one edge -> Output=0, InputRecv=0, AccInv=0 at Addr=0x4000.
//   2. User write: KernelFlag=0, Addr=0x4000, WriteData=0x1234, WriteFlag=1 for one edge.
//      Then read 0x4000 -> ReadData=0x1234, AccInv=0.
//   3. Kernel protection:
//      - KernelFlag=0, write 0xBEEF to 0x0005 -> AccInv=1.
//      - Then KernelFlag=1, read 0x0005 -> prior value, not 0xBEEF.
//      - KernelFlag=1 write 0xBEEF, then read -> 0xBEEF.
//   4. Output port:
//      - Write 0x00A5 to 0xFFFF -> Output=0x00A5 after the edge.
//      - Read 0xFFFF -> ReadData=0x00A5.
//      - Write to 0xFFFE -> AccInv=1, no state change.
//   5. Input handshake:
//      - Input=0x0042, read 0xFFFE -> ReadData=0x0042 and InputRecv=1 after the edge.
//      - InputRecv stays 1 with Addr moved away.
//      - InputRst=1 for one edge -> 0; InputRst together with an IN read -> stays 0.
//   6. Invalid address: read 0x8000 -> AccInv=1, ReadData=0.
//      Read 0x4000+2**AW -> AccInv=1.

Source files
------------

// File: rtl/memory_unit_pkg.sv
// Shared address-map constants, region decode type and decode helper for the memory unit.
package memory_unit_pkg;

  localparam logic [15:0] KERNEL_BASE = 16'h0000;
  localparam logic [15:0] USER_BASE   = 16'h4000;
  localparam logic [15:0] IN_ADDR     = 16'hFFFE;
  localparam logic [15:0] OUT_ADDR    = 16'hFFFF;

  typedef enum logic [2:0] {REG_KERNEL, REG_USER, REG_IN, REG_OUT, REG_BAD} regionT;

  // Region only; bank-offset range and privilege are checked by the caller.
  function automatic regionT decodeRegion(logic [15:0] addr);
    if (addr == IN_ADDR)                         return REG_IN;
    if (addr == OUT_ADDR)                        return REG_OUT;
    if (addr[15:14] == KERNEL_BASE[15:14])       return REG_KERNEL;
    if (addr[15:14] == USER_BASE[15:14])         return REG_USER;
    return REG_BAD;
  endfunction

endpackage

// File: rtl/memory_unit_if.sv
// Processor-side access bus of the memory unit, including the I/O port signals.
interface memory_unit_if;
  logic [15:0] Addr;
  logic [15:0] WriteData;
  logic        WriteFlag;
  logic        KernelFlag;
  logic [15:0] Input;
  logic        InputRst;
  logic [15:0] Output;
  logic [15:0] ReadData;
  logic        AccInv;
  logic        InputRecv;

  modport master (
    output Addr, WriteData, WriteFlag, KernelFlag, Input, InputRst,
    input  Output, ReadData, AccInv, InputRecv
  );

  modport slave (
    input  Addr, WriteData, WriteFlag, KernelFlag, Input, InputRst,
    output Output, ReadData, AccInv, InputRecv
  );
endinterface

// File: rtl/memory_unit_mem_bank.sv
// 2**AW x 16 RAM bank: asynchronous read, synchronous write, no reset of contents.
module memory_unit_mem_bank #(
  parameter int unsigned AW = 10
) (
  input  logic          Clk,
  input  logic          WriteEn,
  input  logic [AW-1:0] Idx,
  input  logic [15:0]   WriteData,
  output logic [15:0]   ReadData
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge Clk) begin
    if (WriteEn) mem[Idx] <= WriteData;
  end

  assign ReadData = mem[Idx];

endmodule

// File: rtl/memory_unit.sv
// Data memory with kernel/user banks, memory-mapped output register and input port.
// Decodes each access combinationally and flags illegal ones on AccInv.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input logic             Clk,
  input logic             Rst,
  memory_unit_if.slave    bus
);

  regionT      region;
  logic        bankOk;
  logic        accInv;
  logic        writeOk;
  logic        kernWe;
  logic        userWe;
  logic [15:0] kernRd;
  logic [15:0] userRd;
  logic [15:0] readData;
  logic [15:0] outputQ;
  logic        inputRecvQ;

  always_comb begin
    region  = decodeRegion(bus.Addr);
    bankOk  = (bus.Addr[13:AW] == '0);
    accInv  = 1'b1;
    case (region)
      REG_KERNEL: accInv = !bankOk || !bus.KernelFlag;
      REG_USER:   accInv = !bankOk;
      REG_IN:     accInv = bus.WriteFlag;
      REG_OUT:    accInv = 1'b0;
      default:    accInv = 1'b1;
    endcase

    // Reset blocks every write on the same edge, including the RAM banks.
    writeOk = bus.WriteFlag && !accInv && !Rst;
    kernWe  = writeOk && (region == REG_KERNEL);
    userWe  = writeOk && (region == REG_USER);

    readData = '0;
    if (!accInv) begin
      case (region)
        REG_KERNEL: readData = kernRd;
        REG_USER:   readData = userRd;
        REG_IN:     readData = bus.Input;
        REG_OUT:    readData = outputQ;
        default:    readData = '0;
      endcase
    end
  end

  memory_unit_mem_bank #(.AW(AW)) u_kern_bank (
    .Clk       (Clk),
    .WriteEn   (kernWe),
    .Idx       (bus.Addr[AW-1:0]),
    .WriteData (bus.WriteData),
    .ReadData  (kernRd)
  );

  memory_unit_mem_bank #(.AW(AW)) u_user_bank (
    .Clk       (Clk),
    .WriteEn   (userWe),
    .Idx       (bus.Addr[AW-1:0]),
    .WriteData (bus.WriteData),
    .ReadData  (userRd)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      outputQ <= '0;
    end else if (writeOk && (region == REG_OUT)) begin
      outputQ <= bus.WriteData;
    end
  end

  // Clear (reset or InputRst) wins over a simultaneous consume of the input port.
  always_ff @(posedge Clk) begin
    if (Rst || bus.InputRst) begin
      inputRecvQ <= 1'b0;
    end else if ((bus.Addr == IN_ADDR) && !bus.WriteFlag) begin
      inputRecvQ <= 1'b1;
    end
  end

  assign bus.ReadData  = readData;
  assign bus.AccInv    = accInv;
  assign bus.Output    = outputQ;
  assign bus.InputRecv = inputRecvQ;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed scenarios followed by random traffic
// compared against an address-map reference model built on associative arrays.
module tb_memory_unit;

  localparam int AW = 10;
  localparam int BankWords = 1 << AW;

  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  memory_unit_if bus ();

  memory_unit #(.AW(AW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  // Reference state
  logic [15:0] kMem [int];
  logic [15:0] uMem [int];
  logic [15:0] outModel;
  logic        recvModel;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit expInv(input int addr, input bit wf, input bit kf);
    int off;
    if (addr == 16'hFFFE) return wf;
    if (addr == 16'hFFFF) return 1'b0;
    if (addr >= 16'h8000) return 1'b1;
    off = addr % 16'h4000;
    if (off >= BankWords) return 1'b1;
    if (addr < 16'h4000) return !kf;
    return 1'b0;
  endfunction

  task automatic drive(input logic [15:0] addr, input logic [15:0] wd, input bit wf,
                       input bit kf, input logic [15:0] inp, input bit irst, input bit rst);
    bus.Addr       = addr;
    bus.WriteData  = wd;
    bus.WriteFlag  = wf;
    bus.KernelFlag = kf;
    bus.Input      = inp;
    bus.InputRst   = irst;
    Rst            = rst;
  endtask

  // Compare all outputs against the model for the currently driven access.
  task automatic checkModel();
    int  a;
    bit  inv;
    bit  known;
    logic [15:0] exp;
    a     = int'(bus.Addr);
    inv   = expInv(a, bus.WriteFlag, bus.KernelFlag);
    known = 1'b1;
    exp   = '0;
    if (!inv) begin
      if (a == 16'hFFFE) exp = bus.Input;
      else if (a == 16'hFFFF) exp = outModel;
      else if (a < 16'h4000) begin
        known = kMem.exists(a);
        if (known) exp = kMem[a];
      end else begin
        known = uMem.exists(a - 16'h4000);
        if (known) exp = uMem[a - 16'h4000];
      end
    end
    checkVal("accinv", {31'd0, bus.AccInv}, {31'd0, inv});
    if (known) checkVal("readdata", {16'd0, bus.ReadData}, {16'd0, exp});
    checkVal("output", {16'd0, bus.Output}, {16'd0, outModel});
    checkVal("inputrecv", {31'd0, bus.InputRecv}, {31'd0, recvModel});
  endtask

  // Advance one edge, updating the model from the values driven before it.
  task automatic tick();
    int a;
    bit inv;
    a   = int'(bus.Addr);
    inv = expInv(a, bus.WriteFlag, bus.KernelFlag);
    if (Rst) begin
      outModel  = '0;
      recvModel = 1'b0;
    end else begin
      if (bus.WriteFlag && !inv) begin
        if (a == 16'hFFFF) outModel = bus.WriteData;
        else if (a < 16'h4000) kMem[a] = bus.WriteData;
        else uMem[a - 16'h4000] = bus.WriteData;
      end
      if (bus.InputRst) recvModel = 1'b0;
      else if (a == 16'hFFFE && !bus.WriteFlag) recvModel = 1'b1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic cycle(input logic [15:0] addr, input logic [15:0] wd, input bit wf,
                       input bit kf, input logic [15:0] inp, input bit irst, input bit rst);
    drive(addr, wd, wf, kf, inp, irst, rst);
    #2;
    checkModel();
    tick();
  endtask

  initial begin
    logic [15:0] addr;
    outModel  = '0;
    recvModel = 1'b0;
    drive(16'h4000, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    @(posedge Clk);
    #1;

    // Reset state
    drive(16'h4000, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    checkVal("rst_output", {16'd0, bus.Output}, 32'h0);
    checkVal("rst_inputrecv", {31'd0, bus.InputRecv}, 32'h0);
    checkVal("rst_accinv", {31'd0, bus.AccInv}, 32'h0);

    // User write then readback
    drive(16'h4000, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    drive(16'h4000, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    checkVal("user_rd", {16'd0, bus.ReadData}, 32'h1234);
    checkVal("user_accinv", {31'd0, bus.AccInv}, 32'h0);

    // Kernel protection
    cycle(16'h0005, 16'h1111, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
    drive(16'h0005, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    checkVal("kern_user_wr_inv", {31'd0, bus.AccInv}, 32'h1);
    checkVal("kern_user_wr_rd0", {16'd0, bus.ReadData}, 32'h0);
    tick();
    drive(16'h0005, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    #2;
    checkVal("kern_prior", {16'd0, bus.ReadData}, 32'h1111);
    cycle(16'h0005, 16'hBEEF, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
    drive(16'h0005, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    #2;
    checkVal("kern_new", {16'd0, bus.ReadData}, 32'hBEEF);

    // Output port
    cycle(16'hFFFF, 16'h00A5, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkVal("out_reg", {16'd0, bus.Output}, 32'h00A5);
    drive(16'hFFFF, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    checkVal("out_rd", {16'd0, bus.ReadData}, 32'h00A5);
    drive(16'hFFFE, 16'h5A5A, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    checkVal("in_wr_inv", {31'd0, bus.AccInv}, 32'h1);
    tick();
    checkVal("in_wr_out_kept", {16'd0, bus.Output}, 32'h00A5);
    checkVal("in_wr_recv_kept", {31'd0, bus.InputRecv}, 32'h0);

    // Input handshake
    drive(16'hFFFE, 16'h0, 1'b0, 1'b0, 16'h0042, 1'b0, 1'b0);
    #2;
    checkVal("in_rd", {16'd0, bus.ReadData}, 32'h0042);
    tick();
    checkVal("recv_set", {31'd0, bus.InputRecv}, 32'h1);
    cycle(16'h4000, 16'h0, 1'b0, 1'b0, 16'h0042, 1'b0, 1'b0);
    checkVal("recv_sticky", {31'd0, bus.InputRecv}, 32'h1);
    cycle(16'h4000, 16'h0, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b0);
    checkVal("recv_clr", {31'd0, bus.InputRecv}, 32'h0);
    cycle(16'hFFFE, 16'h0, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b0);
    checkVal("recv_clr_wins", {31'd0, bus.InputRecv}, 32'h0);

    // Invalid addresses
    drive(16'h8000, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    #2;
    checkVal("bad_inv", {31'd0, bus.AccInv}, 32'h1);
    checkVal("bad_rd0", {16'd0, bus.ReadData}, 32'h0);
    drive(16'(16'h4000 + BankWords), 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    checkVal("oob_inv", {31'd0, bus.AccInv}, 32'h1);
    tick();

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 5))
        0:       addr = 16'($urandom_range(0, 15));
        1:       addr = 16'(16'h4000 + $urandom_range(0, 15));
        2:       addr = 16'hFFFE;
        3:       addr = 16'hFFFF;
        4:       addr = 16'($urandom);
        default: addr = 16'(16'h4000 | ($urandom & 32'h3FFF));
      endcase
      cycle(addr, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
